// File: rtl/muladd_pkg.sv
// Shared types and constants for the iterative MULADD sequencer.
package muladd_pkg;

    localparam int MULADD_WIDTH = 32;
    localparam logic [2:0] ALU_MULADD = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muladd_state_t;

endpackage

// File: rtl/muladd_step.sv
// One shift-add iteration of b*c + a; a single WIDTH-bit adder serves both
// the initial addend (preloaded into acc) and every partial product.
module muladd_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH-1:0] addend;

    assign addend      = mplier[0] ? mcand : '0;
    assign acc_next    = acc + addend;
    assign mcand_next  = {mcand[WIDTH-2:0], 1'b0};
    assign mplier_next = {1'b0, mplier[WIDTH-1:1]};

endmodule

// File: rtl/muladd_seq.sv
// Multi-cycle MULADD sequencer (result = b*c + a) that stalls the pipeline while busy.
// Optional op/stall statistics counters are built when MULADD_STATS_EN is defined.
module muladd_seq
    import muladd_pkg::*;
#(
    parameter int WIDTH = MULADD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] op_cnt,
    output logic [WIDTH-1:0] stall_cnt
);

    muladd_state_t state, state_next;

    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_next, mcand_next, mplier_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last;

    muladd_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc),
        .mcand       (mcand),
        .mplier      (mplier),
        .acc_next    (acc_next),
        .mcand_next  (mcand_next),
        .mplier_next (mplier_next)
    );

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (flush) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall asserts in the accept cycle itself so the MULADD never leaves EX early.
    assign stall = accept || (state == RUN);
    assign busy  = (state == RUN);
    assign done  = (state == DONE) && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= a;
                        mcand  <= b;
                        mplier <= c;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last && !flush) result <= acc_next;
                end
                default: ;
            endcase
        end
    end

`ifdef MULADD_STATS_EN
    logic [WIDTH-1:0] op_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            stall_q <= '0;
        end else begin
            if (done)  op_q    <= op_q + WIDTH'(1);
            if (stall) stall_q <= stall_q + WIDTH'(1);
        end
    end

    assign op_cnt    = op_q;
    assign stall_cnt = stall_q;
`else
    assign op_cnt    = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_muladd_seq.sv
// Directed self-checking bench for muladd_seq (default WIDTH=32).
module tb_muladd_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         stall, busy, done;
    logic [W-1:0] result, op_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;
    int exp_stalls = 0;

    muladd_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .c         (c),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .op_cnt    (op_cnt),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] stats_exp(input int v);
`ifdef MULADD_STATS_EN
        return W'(v);
`else
        return '0;
`endif
    endfunction

    // Entered in the accept cycle (IDLE, start high); leaves in the DONE cycle.
    task automatic run_from_accept(input string name, input logic [W-1:0] exp, input bit flush_in_done);
        int bad;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL %s_accept_stall: got %b expected 1", name, stall);
        end
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (stall !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL %s_run_window: %0d bad cycles expected 0", name, bad);
        end
        tick();
        exp_stalls += 33;
        if (flush_in_done) begin
            flush = 1'b1;
            start = 1'b0;
            #1;
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL %s_flushed_done: got %b expected 0", name, done);
            end
        end else begin
            exp_ops += 1;
            checks++;
            if (done !== 1'b1 || stall !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL %s_done_cycle: done=%b stall=%b busy=%b expected 1 0 0", name, done, stall, busy);
            end
            checks++;
            if (result !== exp) begin
                errors++; $display("FAIL %s_result: got %h expected %h", name, result, exp);
            end
        end
    endtask

    task automatic check_idle(input string name, input logic [W-1:0] exp_res);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL %s_idle: busy=%b done=%b stall=%b expected 0 0 0", name, busy, done, stall);
        end
        checks++;
        if (result !== exp_res) begin
            errors++; $display("FAIL %s_hold_result: got %h expected %h", name, result, exp_res);
        end
        checks++;
        if (op_cnt !== stats_exp(exp_ops) || stall_cnt !== stats_exp(exp_stalls)) begin
            errors++; $display("FAIL %s_stats: op_cnt=%0d stall_cnt=%0d expected %0d %0d",
                               name, op_cnt, stall_cnt, stats_exp(exp_ops), stats_exp(exp_stalls));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_ops = 0;
        exp_stalls = 0;
        #1;
        check_idle("reset", '0);
    endtask

    task automatic test_basic();
        a = 5; b = 3; c = 4; start = 1'b1;
        #1;
        run_from_accept("basic", 32'd17, 1'b0);
        start = 1'b0;
        tick();
        check_idle("basic_after", 32'd17);
    endtask

    task automatic test_flush_run();
        a = 9; b = 9; c = 9; start = 1'b1;
        #1;
        for (int i = 1; i <= 10; i++) tick();
        flush = 1'b1;
        start = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL flush_cycle10: stall=%b busy=%b expected 1 1", stall, busy);
        end
        tick();
        flush = 1'b0;
        exp_stalls += 11;
        #1;
        check_idle("flush_run", 32'd17);
        tick();
        tick();
        check_idle("flush_run_later", 32'd17);
    endtask

    task automatic test_flush_done();
        a = 1; b = 2; c = 3; start = 1'b1;
        #1;
        run_from_accept("flush_done", 32'd7, 1'b1);
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || op_cnt !== stats_exp(exp_ops)) begin
            errors++; $display("FAIL flush_done_after: busy=%b done=%b stall=%b op_cnt=%0d expected 0 0 0 %0d",
                               busy, done, stall, op_cnt, stats_exp(exp_ops));
        end
    endtask

    task automatic test_wrap();
        a = 32'd1; b = 32'hFFFF_FFFF; c = 32'd2; start = 1'b1;
        #1;
        run_from_accept("wrap1", 32'hFFFF_FFFF, 1'b0);
        start = 1'b0;
        tick();
        a = 32'd0; b = 32'h0001_0000; c = 32'h0001_0000; start = 1'b1;
        #1;
        run_from_accept("wrap2", 32'd0, 1'b0);
        start = 1'b0;
        tick();
        check_idle("wrap_after", 32'd0);
    endtask

    task automatic test_reset_mid();
        a = 5; b = 3; c = 4; start = 1'b1;
        #1;
        for (int i = 1; i <= 20; i++) tick();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        exp_ops = 0;
        exp_stalls = 0;
        #1;
        check_idle("reset_mid", '0);
        a = 32'd100; b = 32'd12; c = 32'd11; start = 1'b1;
        #1;
        run_from_accept("after_reset", 32'd232, 1'b0);
        start = 1'b0;
        tick();
        check_idle("after_reset_idle", 32'd232);
    endtask

    task automatic test_flush_idle();
        start = 1'b1;
        flush = 1'b1;
        a = 1; b = 1; c = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_idle_state: busy=%b stall=%b done=%b expected 0 0 0", busy, stall, done);
        end
        start = 1'b0;
        flush = 1'b0;
        tick();
        check_idle("flush_idle_after", 32'd232);
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ops = 0;
        exp_stalls = 0;
        a = 2; b = 7; c = 6; start = 1'b1;
        #1;
        run_from_accept("b2b_op1", 32'd44, 1'b0);
        a = 0; b = 9; c = 9;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin
            errors++; $display("FAIL b2b_issue_cycle: busy=%b done=%b stall=%b expected 0 0 1", busy, done, stall);
        end
        run_from_accept("b2b_op2", 32'd81, 1'b0);
        start = 1'b0;
        tick();
        check_idle("b2b_after", 32'd81);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_run();
        test_flush_done();
        test_wrap();
        test_reset_mid();
        test_flush_idle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
